// File: rtl/prom_loader.sv
// prom_loader: program memory with a byte-stream loader.
// A load request (LOAD_START) streams 2**ADDR_W instruction words into the
// memory. Each word arrives as two bytes: a high byte carrying bits [14:8]
// (bit 7 must be 0), followed by a low byte carrying bits [7:0]. The fetch
// port returns the registered word at P_COUNT one cycle later. It returns a
// NOP (0) while a load is in progress.
//
// Ports
//   CLK         rising-edge clock
//   RESET       synchronous active-high reset (memory contents are kept)
//   LOAD_START  one-cycle request to begin a full image load (IDLE only)
//   DIN         loader byte stream
//   DIN_VALID   DIN holds a valid byte
//   DIN_READY   loader accepts a byte this cycle
//   P_COUNT     fetch address (upper bits beyond ADDR_W are ignored)
//   PROM_OUT    registered instruction word
//   LOAD_BUSY   load in progress
//   LOAD_DONE   one-cycle pulse after the last word has been written
//   LOAD_ERR    sticky flag: a high byte had bit 7 set
module prom_loader #(
    parameter int ADDR_W = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LOAD_START,
    input  logic [7:0]  DIN,
    input  logic        DIN_VALID,
    output logic        DIN_READY,
    input  logic [7:0]  P_COUNT,
    output logic [14:0] PROM_OUT,
    output logic        LOAD_BUSY,
    output logic        LOAD_DONE,
    output logic        LOAD_ERR
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HI    = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [6:0]        hi_q;
    logic [7:0]        lo_q;
    logic              accept;
    logic              unused_pc;

    logic [14:0] mem [DEPTH];

    // Handshake and status flags are pure functions of the state register,
    // so they are all low one cycle after reset without needing flops.
    always_comb begin
        DIN_READY = (state == S_HI) || (state == S_LO);
        accept    = DIN_READY && DIN_VALID;
        LOAD_BUSY = (state != S_IDLE);
        LOAD_DONE = (state == S_DONE);
    end

    // Only the low ADDR_W bits of P_COUNT address the memory; the rest wrap.
    assign unused_pc = ^P_COUNT;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            addr     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            LOAD_ERR <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (LOAD_START) begin
                        addr     <= '0;
                        LOAD_ERR <= 1'b0;
                        state    <= S_HI;
                    end
                end
                S_HI: begin
                    if (accept) begin
                        if (DIN[7]) begin
                            // Malformed header: abort, keep the words already written.
                            LOAD_ERR <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            hi_q  <= DIN[6:0];
                            state <= S_LO;
                        end
                    end
                end
                S_LO: begin
                    if (accept) begin
                        lo_q  <= DIN;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Stop at the last address; never wrap into a second pass.
                    if (addr == LAST_ADDR) begin
                        state <= S_DONE;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= S_HI;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory is not reset. A reset in the WRITE cycle suppresses the write.
    always_ff @(posedge CLK) begin
        if (!RESET && state == S_WRITE) begin
            mem[addr] <= {hi_q, lo_q};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            PROM_OUT <= '0;
        end else if (LOAD_BUSY) begin
            PROM_OUT <= '0;
        end else begin
            PROM_OUT <= mem[P_COUNT[ADDR_W-1:0]];
        end
    end

endmodule

// File: tb/tb_prom_loader.sv
// Scoreboard bench for prom_loader. Read requests push their expected word
// into exp_q. A monitor pops and compares one cycle later, when PROM_OUT
// presents the registered result.
module tb_prom_loader;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        LOAD_START;
    logic [7:0]  DIN;
    logic        DIN_VALID;
    logic        DIN_READY;
    logic [7:0]  P_COUNT;
    logic [14:0] PROM_OUT;
    logic        LOAD_BUSY;
    logic        LOAD_DONE;
    logic        LOAD_ERR;

    prom_loader #(.ADDR_W(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .LOAD_START (LOAD_START),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .DIN_READY  (DIN_READY),
        .P_COUNT    (P_COUNT),
        .PROM_OUT   (PROM_OUT),
        .LOAD_BUSY  (LOAD_BUSY),
        .LOAD_DONE  (LOAD_DONE),
        .LOAD_ERR   (LOAD_ERR)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic [14:0] exp_q[$];
    logic [7:0]  bytes_q[$];
    logic [14:0] model[16];
    logic        rd_req = 1'b0;
    logic        rd_req_d = 1'b0;

    always @(posedge CLK) rd_req_d <= rd_req;

    // Monitor: PROM_OUT is valid one cycle after a read request.
    always @(negedge CLK) begin
        logic [14:0] e;
        if (rd_req_d) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_underflow: got 0x%0h with no expected word", PROM_OUT);
            end else begin
                e = exp_q.pop_front();
                if (PROM_OUT !== e) begin
                    n_err++;
                    $display("FAIL prom_out: got 0x%0h expected 0x%0h", PROM_OUT, e);
                end
            end
        end
        if (LOAD_DONE === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic rd(input logic [7:0] pc, input logic [14:0] exp);
        P_COUNT = pc;
        exp_q.push_back(exp);
        rd_req = 1'b1;
        @(negedge CLK);
        rd_req = 1'b0;
    endtask

    task automatic rd_all();
        for (int i = 0; i < 16; i++) rd(8'(i), model[i]);
    endtask

    task automatic push_word(input logic [14:0] w);
        bytes_q.push_back({1'b0, w[14:8]});
        bytes_q.push_back(w[7:0]);
    endtask

    task automatic start_load();
        LOAD_START = 1'b1;
        @(negedge CLK);
        LOAD_START = 1'b0;
    endtask

    // Offer queued bytes; optionally toggle DIN_VALID every cycle.
    task automatic stream(input bit toggle);
        int idx = 0;
        int cyc = 0;
        bit ph  = 1'b1;
        while (idx < bytes_q.size() && cyc < 4000) begin
            DIN       = bytes_q[idx];
            DIN_VALID = toggle ? ph : 1'b1;
            if (DIN_VALID && DIN_READY) idx++;
            @(negedge CLK);
            ph = ~ph;
            cyc++;
        end
        DIN_VALID = 1'b0;
        check("stream_complete", 32'(idx), 32'(bytes_q.size()));
        bytes_q.delete();
    endtask

    task automatic wait_idle();
        int g = 0;
        while (LOAD_BUSY !== 1'b0 && g < 100) begin
            @(negedge CLK);
            g++;
        end
        check("wait_idle_timeout", 32'(g < 100), 32'd1);
    endtask

    initial begin
        logic [14:0] w;

        RESET = 1'b1; LOAD_START = 1'b0; DIN = '0; DIN_VALID = 1'b0; P_COUNT = '0;
        repeat (3) @(negedge CLK);
        check("rst_prom_out", 32'(PROM_OUT), 32'h0);
        check("rst_din_ready", 32'(DIN_READY), 32'h0);
        check("rst_busy", 32'(LOAD_BUSY), 32'h0);
        check("rst_done", 32'(LOAD_DONE), 32'h0);
        check("rst_err", 32'(LOAD_ERR), 32'h0);
        RESET = 1'b0;
        @(negedge CLK);

        // Full load, DIN_VALID held high.
        for (int i = 0; i < 16; i++) begin
            w = 15'(15'h4800 + i);
            push_word(w);
            model[i] = w;
        end
        start_load();
        check("busy_after_start", 32'(LOAD_BUSY), 32'h1);
        check("ready_in_hi", 32'(DIN_READY), 32'h1);
        stream(1'b0);
        wait_idle();
        check("done_count_1", 32'(done_cnt), 32'd1);
        check("err_after_full", 32'(LOAD_ERR), 32'h0);
        rd_all();

        // Address wrap on the fetch port.
        rd(8'h1A, model[10]);
        rd(8'hFF, model[15]);
        rd(8'h20, model[0]);

        // Backpressure: DIN_VALID toggles every cycle.
        for (int i = 0; i < 16; i++) begin
            w = 15'(15'h2A50 ^ (i * 15'h0413));
            push_word(w);
            model[i] = w;
        end
        start_load();
        stream(1'b1);
        wait_idle();
        check("done_count_2", 32'(done_cnt), 32'd2);
        rd_all();

        // Bad header as the fifth byte.
        push_word(15'h7F00); model[0] = 15'h7F00;
        push_word(15'h7F01); model[1] = 15'h7F01;
        bytes_q.push_back(8'h80);
        start_load();
        stream(1'b0);
        check("bad_hdr_err", 32'(LOAD_ERR), 32'h1);
        check("bad_hdr_idle", 32'(LOAD_BUSY), 32'h0);
        check("bad_hdr_ready", 32'(DIN_READY), 32'h0);
        @(negedge CLK);
        check("bad_hdr_err_sticky", 32'(LOAD_ERR), 32'h1);
        check("bad_hdr_no_done", 32'(done_cnt), 32'd2);
        rd_all();
        start_load();
        check("start_clears_err", 32'(LOAD_ERR), 32'h0);

        // Reset after the high byte of word 3, colliding with a low byte.
        push_word(15'h0111); model[0] = 15'h0111;
        push_word(15'h0222); model[1] = 15'h0222;
        push_word(15'h0333); model[2] = 15'h0333;
        bytes_q.push_back(8'h12);
        stream(1'b0);
        DIN = 8'h34; DIN_VALID = 1'b1; RESET = 1'b1;
        @(negedge CLK);
        check("midrst_prom_out", 32'(PROM_OUT), 32'h0);
        check("midrst_ready", 32'(DIN_READY), 32'h0);
        check("midrst_busy", 32'(LOAD_BUSY), 32'h0);
        check("midrst_done", 32'(LOAD_DONE), 32'h0);
        check("midrst_err", 32'(LOAD_ERR), 32'h0);
        RESET = 1'b0; DIN_VALID = 1'b0;
        @(negedge CLK);
        check("midrst_stays_idle", 32'(LOAD_BUSY), 32'h0);
        rd_all();

        // NOP output while busy; LOAD_START mid-load must not restart it.
        start_load();
        for (int i = 0; i < 2; i++) begin
            w = 15'(15'h3C00 + i * 15'h0101);
            push_word(w);
            model[i] = w;
        end
        stream(1'b0);
        rd(8'h05, 15'h0);
        rd(8'h05, 15'h0);
        LOAD_START = 1'b1;
        rd(8'h0A, 15'h0);
        LOAD_START = 1'b0;
        rd(8'h1A, 15'h0);
        for (int i = 2; i < 16; i++) begin
            w = 15'(15'h3C00 + i * 15'h0101);
            push_word(w);
            model[i] = w;
        end
        stream(1'b0);
        wait_idle();
        check("done_count_3", 32'(done_cnt), 32'd3);
        rd_all();

        repeat (2) @(negedge CLK);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
